// File: rtl/polar_averager.sv
// Gain-compensated boxcar averager for CORDIC magnitude/phase; one decimated result per 2^LOG2_N samples.
// Optional input gain stage enabled by defining POLAR_AVG_GAIN_COMP_EN (adds one cycle of latency).
module polar_averager #(
  parameter int XY_W   = 17,
  parameter int TH_W   = 17,
  parameter int LOG2_N = 4,
  parameter int GAIN_Q = 19899
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   in_valid,
  input  logic [XY_W-1:0]        mag_i,
  input  logic signed [TH_W-1:0] phase_i,
  output logic                   out_valid,
  output logic [XY_W-1:0]        mag_o,
  output logic signed [TH_W-1:0] phase_o
);

  localparam int MA_W = XY_W + LOG2_N;
  localparam int PA_W = TH_W + LOG2_N;
  localparam int HALF = 2 ** (LOG2_N - 1);
  localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'((2 ** LOG2_N) - 1);
  localparam logic [MA_W:0] MAG_MAX = (MA_W + 1)'((2 ** XY_W) - 1);

  logic                   a_valid_s;
  logic [XY_W-1:0]        a_mag_s;
  logic signed [TH_W-1:0] a_ph_s;

`ifdef POLAR_AVG_GAIN_COMP_EN
  localparam logic [XY_W+15:0] GAIN_C = (XY_W + 16)'(GAIN_Q);
  localparam logic [XY_W+15:0] G_HALF = (XY_W + 16)'(16384);

  logic [XY_W+15:0]       g_rnd_s;
  logic                   v_g_r;
  logic [XY_W-1:0]        mag_g_r;
  logic signed [TH_W-1:0] phase_g_r;

  // One extra bit over the product keeps the rounding add from wrapping for any GAIN_Q < 1.0.
  assign g_rnd_s = ((XY_W + 16)'(mag_i) * GAIN_C) + G_HALF;

  // Gain stage: scale magnitude by 1/K, pass phase and valid through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_g_r     <= 1'b0;
      mag_g_r   <= '0;
      phase_g_r <= '0;
    end else if (clear_i) begin
      v_g_r     <= 1'b0;
      mag_g_r   <= mag_g_r;
      phase_g_r <= phase_g_r;
    end else begin
      v_g_r     <= in_valid;
      mag_g_r   <= g_rnd_s[XY_W+14:15];
      phase_g_r <= phase_i;
    end
  end

  assign a_valid_s = v_g_r;
  assign a_mag_s   = mag_g_r;
  assign a_ph_s    = phase_g_r;
`else
  assign a_valid_s = in_valid;
  assign a_mag_s   = mag_i;
  assign a_ph_s    = phase_i;
`endif

  logic [LOG2_N-1:0]      cnt_r;
  logic [MA_W-1:0]        mag_acc_r;
  logic signed [PA_W-1:0] ph_acc_r;
  logic [MA_W-1:0]        mag_sum_s;
  logic signed [PA_W-1:0] ph_sum_s;
  logic                   close_r;
  logic [MA_W-1:0]        fin_mag_r;
  logic signed [PA_W-1:0] fin_ph_r;

  assign mag_sum_s = mag_acc_r + MA_W'(a_mag_s);
  assign ph_sum_s  = ph_acc_r + {{LOG2_N{a_ph_s[TH_W-1]}}, a_ph_s};

  // Accumulate stage; the closing sample's sum is parked in fin_* and the accumulators restart at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= '0;
      mag_acc_r <= '0;
      ph_acc_r  <= '0;
      close_r   <= 1'b0;
      fin_mag_r <= '0;
      fin_ph_r  <= '0;
    end else if (clear_i) begin
      cnt_r     <= '0;
      mag_acc_r <= '0;
      ph_acc_r  <= '0;
      close_r   <= 1'b0;
    end else if (a_valid_s && (cnt_r == CNT_LAST)) begin
      cnt_r     <= '0;
      mag_acc_r <= '0;
      ph_acc_r  <= '0;
      close_r   <= 1'b1;
      fin_mag_r <= mag_sum_s;
      fin_ph_r  <= ph_sum_s;
    end else if (a_valid_s) begin
      cnt_r     <= cnt_r + LOG2_N'(1);
      mag_acc_r <= mag_sum_s;
      ph_acc_r  <= ph_sum_s;
      close_r   <= 1'b0;
    end else begin
      close_r   <= 1'b0;
    end
  end

  logic [MA_W:0]        mag_rnd_s;
  logic [MA_W:0]        mag_sh_s;
  logic [XY_W-1:0]      mag_sat_s;
  logic signed [PA_W:0] ph_rnd_s;
  logic signed [PA_W:0] ph_sh_s;

  assign mag_rnd_s = {1'b0, fin_mag_r} + (MA_W + 1)'(HALF);
  assign mag_sh_s  = mag_rnd_s >> LOG2_N;
  assign ph_rnd_s  = {fin_ph_r[PA_W-1], fin_ph_r} + (PA_W + 1)'(HALF);
  assign ph_sh_s   = ph_rnd_s >>> LOG2_N;

  // Clamp the rounded mean to the output magnitude range.
  always_comb begin
    mag_sat_s = '0;
    if (mag_sh_s > MAG_MAX) begin
      mag_sat_s = MAG_MAX[XY_W-1:0];
    end else begin
      mag_sat_s = mag_sh_s[XY_W-1:0];
    end
  end

  logic                   rnd_valid_r;
  logic [XY_W-1:0]        mag_rnd_r;
  logic signed [TH_W-1:0] ph_rnd_r;

  // Rounding stage, then output stage; clear cancels anything not yet on the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd_valid_r <= 1'b0;
      mag_rnd_r   <= '0;
      ph_rnd_r    <= '0;
      out_valid   <= 1'b0;
      mag_o       <= '0;
      phase_o     <= '0;
    end else if (clear_i) begin
      rnd_valid_r <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      rnd_valid_r <= close_r;
      out_valid   <= rnd_valid_r;
      if (close_r) begin
        mag_rnd_r <= mag_sat_s;
        ph_rnd_r  <= ph_sh_s[TH_W-1:0];
      end
      if (rnd_valid_r) begin
        mag_o   <= mag_rnd_r;
        phase_o <= ph_rnd_r;
      end
    end
  end

endmodule
